// File: rtl/hazard_exc_ctrl_pkg.sv
// Shared definitions for the hazard/exception controller: PC mux codes,
// register sentinel, FSM state encoding and the packed control bundle.
package hazard_exc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DRAIN    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [1:0] PC_SEL_SEQ = 2'b00;
    localparam logic [1:0] PC_SEL_BR  = 2'b01;
    localparam logic [1:0] PC_SEL_VEC = 2'b10;
    localparam logic [1:0] PC_SEL_EPC = 2'b11;

    localparam logic [3:0] NOREG_CODE = 4'hF;

    typedef struct packed {
        logic       stall_pc;
        logic       stall_if_id;
        logic       flush_if_id;
        logic       flush_id;
        logic [1:0] pc_sel;
    } ctrl_t;

    // A load in EX whose destination is read by the instruction in ID.
    function automatic logic load_use(input logic       memread,
                                      input logic [3:0] regdst,
                                      input logic [3:0] noreg,
                                      input logic       uses1,
                                      input logic [3:0] src1,
                                      input logic       uses2,
                                      input logic [3:0] src2);
        return memread && (regdst != noreg) &&
               ((uses1 && (src1 == regdst)) || (uses2 && (src2 == regdst)));
    endfunction

endpackage

// File: rtl/hazard_exc_ctrl_if.sv
// Pipeline-side signal bundle of the hazard/exception controller.
// Every signal is a level sampled each CLK cycle; there is no valid/ready pairing.
interface hazard_exc_ctrl_if;
    import hazard_exc_ctrl_pkg::*;

    logic        id_valid_i;
    logic [15:0] id_pc_i;
    logic [3:0]  id_regsrc1_i;
    logic        id_uses1_i;
    logic [3:0]  id_regsrc2_i;
    logic        id_uses2_i;
    logic        ex_memread_i;
    logic [3:0]  ex_regdst_i;
    logic        branch_taken_i;
    logic        eret_i;
    logic        int_req_i;
    logic [3:0]  int_no_i;

    logic        stall_pc_o;
    logic        stall_if_id_o;
    logic        flush_if_id_o;
    logic        flush_id_o;
    logic [1:0]  pc_sel_o;
    logic [15:0] epc_o;
    logic [3:0]  cause_o;
    logic        int_en_o;

    modport master (
        output id_valid_i, id_pc_i, id_regsrc1_i, id_uses1_i, id_regsrc2_i,
               id_uses2_i, ex_memread_i, ex_regdst_i, branch_taken_i, eret_i,
               int_req_i, int_no_i,
        input  stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_o, pc_sel_o,
               epc_o, cause_o, int_en_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_regsrc1_i, id_uses1_i, id_regsrc2_i,
               id_uses2_i, ex_memread_i, ex_regdst_i, branch_taken_i, eret_i,
               int_req_i, int_no_i,
        output stall_pc_o, stall_if_id_o, flush_if_id_o, flush_id_o, pc_sel_o,
               epc_o, cause_o, int_en_o
    );

endinterface

// File: rtl/hazard_exc_ctrl_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level input.
module hazard_exc_ctrl_sync_ff #(
    parameter int STAGES = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) chain <= '0;
        else        chain <= {chain[STAGES-2:0], d};
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/hazard_exc_ctrl.sv
// Pipeline hazard and interrupt controller: load-use stalls, branch/ERET
// redirects, and the take -> DRAIN -> REDIRECT interrupt entry sequence.
module hazard_exc_ctrl
    import hazard_exc_ctrl_pkg::*;
#(
    parameter int         DRAIN_CYCLES = 2,
    parameter int         SYNC_STAGES  = 2,
    parameter bit         INT_EN_RESET = 1'b1,
    parameter logic [3:0] NOREG        = NOREG_CODE
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    hazard_exc_ctrl_if.slave     bus,
    output state_t               dbg_state
);

    state_t      state, state_nxt;
    logic [2:0]  cnt;
    logic [15:0] epc_q;
    logic [3:0]  cause_q;
    logic        int_en_q;
    logic        irq, lu, take, eret_ok;
    ctrl_t       ctrl;

    hazard_exc_ctrl_sync_ff #(.STAGES(SYNC_STAGES)) u_int_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (bus.int_req_i),
        .q     (irq)
    );

    assign lu = load_use(bus.ex_memread_i, bus.ex_regdst_i, NOREG,
                         bus.id_uses1_i, bus.id_regsrc1_i,
                         bus.id_uses2_i, bus.id_regsrc2_i);
    // The interrupt beats every other RUN action; the ID instruction replays after ERET.
    assign take    = irq && int_en_q && bus.id_valid_i;
    assign eret_ok = !lu && bus.eret_i && bus.id_valid_i;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (take) state_nxt = DRAIN;
            DRAIN:    if (cnt == 3'd0) state_nxt = REDIRECT;
            REDIRECT: state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt      <= 3'd0;
            epc_q    <= 16'h0000;
            cause_q  <= 4'h0;
            int_en_q <= INT_EN_RESET;
        end else begin
            case (state)
                RUN: begin
                    if (take) begin
                        epc_q    <= bus.id_pc_i;
                        cause_q  <= bus.int_no_i;
                        int_en_q <= 1'b0;
                        cnt      <= 3'(DRAIN_CYCLES - 1);
                    end else if (eret_ok) begin
                        int_en_q <= 1'b1;
                    end
                end
                DRAIN:   if (cnt != 3'd0) cnt <= cnt - 3'd1;
                default: ;
            endcase
        end
    end

    // Reset forces a clean bubble-free idle, independent of pipeline inputs.
    always_comb begin
        ctrl = '0;
        if (RST_N) begin
            case (state)
                RUN: begin
                    if (take) begin
                        ctrl.stall_pc    = 1'b1;
                        ctrl.flush_if_id = 1'b1;
                        ctrl.flush_id    = 1'b1;
                    end else if (lu) begin
                        ctrl.stall_pc    = 1'b1;
                        ctrl.stall_if_id = 1'b1;
                        ctrl.flush_id    = 1'b1;
                    end else if (eret_ok) begin
                        ctrl.pc_sel      = PC_SEL_EPC;
                        ctrl.flush_if_id = 1'b1;
                    end else if (bus.branch_taken_i && bus.id_valid_i) begin
                        ctrl.pc_sel      = PC_SEL_BR;
                        ctrl.flush_if_id = 1'b1;
                    end
                end
                DRAIN: begin
                    ctrl.stall_pc    = 1'b1;
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id    = 1'b1;
                end
                REDIRECT: begin
                    ctrl.pc_sel      = PC_SEL_VEC;
                    ctrl.flush_if_id = 1'b1;
                    ctrl.flush_id    = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign bus.stall_pc_o    = ctrl.stall_pc;
    assign bus.stall_if_id_o = ctrl.stall_if_id;
    assign bus.flush_if_id_o = ctrl.flush_if_id;
    assign bus.flush_id_o    = ctrl.flush_id;
    assign bus.pc_sel_o      = ctrl.pc_sel;
    assign bus.epc_o         = epc_q;
    assign bus.cause_o       = cause_q;
    assign bus.int_en_o      = int_en_q;
    assign dbg_state         = state;

endmodule

// File: tb/tb_hazard_exc_ctrl.sv
// Directed and randomised bench for hazard_exc_ctrl with an expected-output queue.
module tb_hazard_exc_ctrl;
  import hazard_exc_ctrl_pkg::*;

  // Expected control vector order: {stall_pc, stall_if_id, flush_if_id, flush_id, pc_sel}
  localparam logic [5:0] E_IDLE  = 6'b000000;
  localparam logic [5:0] E_LU    = 6'b110100;
  localparam logic [5:0] E_BR    = 6'b001001;
  localparam logic [5:0] E_ERET  = 6'b001011;
  localparam logic [5:0] E_TAKE  = 6'b101100;
  localparam logic [5:0] E_DRAIN = 6'b101100;
  localparam logic [5:0] E_REDIR = 6'b001110;

  logic   CLK;
  logic   RST_N;
  state_t dbg_state;
  int     n_checks;
  int     n_fail;
  logic [5:0] exp_q[$];

  hazard_exc_ctrl_if bus();

  hazard_exc_ctrl u_dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] observed();
    return {bus.stall_pc_o, bus.stall_if_id_o, bus.flush_if_id_o, bus.flush_id_o, bus.pc_sel_o};
  endfunction

  // Independent RUN-state reference used for the randomised phase (no interrupts).
  function automatic logic [5:0] model_run(input logic valid, input logic memread,
                                           input logic [3:0] dst, input logic u1,
                                           input logic [3:0] s1, input logic u2,
                                           input logic [3:0] s2, input logic br,
                                           input logic er);
    logic hit;
    hit = memread && dst != 4'hF && ((u1 && s1 == dst) || (u2 && s2 == dst));
    if (hit)               return E_LU;
    else if (er && valid)  return E_ERET;
    else if (br && valid)  return E_BR;
    else                   return E_IDLE;
  endfunction

  // driver tasks
  task automatic clear_inputs();
    bus.id_valid_i     = 1'b0;
    bus.id_pc_i        = 16'h0000;
    bus.id_regsrc1_i   = 4'h0;
    bus.id_uses1_i     = 1'b0;
    bus.id_regsrc2_i   = 4'h0;
    bus.id_uses2_i     = 1'b0;
    bus.ex_memread_i   = 1'b0;
    bus.ex_regdst_i    = 4'hF;
    bus.branch_taken_i = 1'b0;
    bus.eret_i         = 1'b0;
    bus.int_no_i       = 4'h0;
  endtask

  // Inputs already driven for this cycle; push expectation, compare at negedge.
  task automatic step(input string tag, input logic [5:0] exp);
    logic [5:0] e;
    exp_q.push_back(exp);
    @(negedge CLK);
    e = exp_q.pop_front();
    check_eq(tag, observed(), e);
    check_eq({tag, "_excl"}, bus.stall_if_id_o & bus.flush_if_id_o, 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST_N    = 1'b0;
    bus.int_req_i = 1'b0;
    clear_inputs();

    // Reset: a live load-use pattern must not reach the outputs.
    bus.id_valid_i = 1'b1; bus.ex_memread_i = 1'b1; bus.ex_regdst_i = 4'h3;
    bus.id_regsrc1_i = 4'h3; bus.id_uses1_i = 1'b1; bus.branch_taken_i = 1'b1;
    @(negedge CLK);
    check_eq("rst_outputs", observed(), E_IDLE);
    check_eq("rst_epc", bus.epc_o, 16'h0000);
    check_eq("rst_cause", bus.cause_o, 4'h0);
    check_eq("rst_int_en", bus.int_en_o, 1'b1);
    check_eq("rst_state", dbg_state, RUN);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    bus.branch_taken_i = 1'b0;

    // Load-use hazards and the NOREG exemption
    step("lu_src1", E_LU);
    bus.ex_regdst_i = 4'hF; bus.id_regsrc1_i = 4'hF;
    step("lu_noreg", E_IDLE);
    bus.ex_regdst_i = 4'h7; bus.id_regsrc1_i = 4'h1; bus.id_uses2_i = 1'b1; bus.id_regsrc2_i = 4'h7;
    step("lu_src2", E_LU);
    bus.id_uses2_i = 1'b0;
    step("lu_unused_src", E_IDLE);

    // Branch alone, then branch shadowed by a load-use
    clear_inputs(); bus.id_valid_i = 1'b1; bus.branch_taken_i = 1'b1;
    step("branch", E_BR);
    bus.ex_memread_i = 1'b1; bus.ex_regdst_i = 4'h2; bus.id_uses1_i = 1'b1; bus.id_regsrc1_i = 4'h2;
    step("branch_vs_lu", E_LU);
    clear_inputs(); bus.branch_taken_i = 1'b1;
    step("branch_no_valid", E_IDLE);
    clear_inputs(); bus.id_valid_i = 1'b1; bus.eret_i = 1'b1; bus.branch_taken_i = 1'b1;
    step("eret_over_branch", E_ERET);

    // Randomised RUN traffic, interrupts quiet
    for (int i = 0; i < 60; i++) begin
      int d;
      d = $urandom_range(0, 4);
      bus.id_valid_i     = 1'($urandom_range(0, 1));
      bus.ex_memread_i   = 1'($urandom_range(0, 1));
      bus.ex_regdst_i    = (d == 4) ? 4'hF : 4'(d);
      bus.id_uses1_i     = 1'($urandom_range(0, 1));
      bus.id_regsrc1_i   = 4'($urandom_range(0, 3));
      bus.id_uses2_i     = 1'($urandom_range(0, 1));
      bus.id_regsrc2_i   = 4'($urandom_range(0, 3));
      bus.branch_taken_i = 1'($urandom_range(0, 1));
      bus.eret_i         = ($urandom_range(0, 7) == 0);
      step("rand_run", model_run(bus.id_valid_i, bus.ex_memread_i, bus.ex_regdst_i,
                                 bus.id_uses1_i, bus.id_regsrc1_i, bus.id_uses2_i,
                                 bus.id_regsrc2_i, bus.branch_taken_i, bus.eret_i));
    end

    // Interrupt entry: two synchroniser edges, then take/DRAIN/DRAIN/REDIRECT
    clear_inputs();
    check_eq("int_en_before", bus.int_en_o, 1'b1);
    bus.id_valid_i = 1'b1; bus.id_pc_i = 16'h0040; bus.int_no_i = 4'h5; bus.int_req_i = 1'b1;
    step("int_sync0", E_IDLE);
    step("int_sync1", E_IDLE);
    step("int_take", E_TAKE);
    check_eq("int_epc", bus.epc_o, 16'h0040);
    check_eq("int_cause", bus.cause_o, 4'h5);
    check_eq("int_en_cleared", bus.int_en_o, 1'b0);
    check_eq("int_state_drain", dbg_state, DRAIN);
    // Pipeline inputs during the sequence must be ignored
    bus.id_pc_i = 16'h0999; bus.branch_taken_i = 1'b1; bus.eret_i = 1'b1;
    bus.ex_memread_i = 1'b1; bus.ex_regdst_i = 4'h1; bus.id_uses1_i = 1'b1; bus.id_regsrc1_i = 4'h1;
    step("int_drain0", E_DRAIN);
    step("int_drain1", E_DRAIN);
    step("int_redirect", E_REDIR);
    check_eq("int_epc_held", bus.epc_o, 16'h0040);
    clear_inputs(); bus.id_valid_i = 1'b1;
    step("handler_idle", E_IDLE);
    check_eq("handler_int_en", bus.int_en_o, 1'b0);

    // ERET with int_req still high; re-acceptance the cycle after
    bus.eret_i = 1'b1;
    step("eret", E_ERET);
    check_eq("eret_int_en", bus.int_en_o, 1'b1);
    bus.eret_i = 1'b0; bus.id_pc_i = 16'h0200;
    step("reaccept_take", E_TAKE);
    step("reaccept_drain0", E_DRAIN);
    step("reaccept_drain1", E_DRAIN);
    step("reaccept_redirect", E_REDIR);
    check_eq("reaccept_epc", bus.epc_o, 16'h0200);

    // Drop the request, re-enable, then interrupt coinciding with a branch
    bus.int_req_i = 1'b0;
    step("drop0", E_IDLE);
    step("drop1", E_IDLE);
    bus.eret_i = 1'b1;
    step("eret2", E_ERET);
    bus.eret_i = 1'b0; bus.id_pc_i = 16'h0123; bus.int_no_i = 4'h9; bus.int_req_i = 1'b1;
    step("br_int_sync0", E_IDLE);
    step("br_int_sync1", E_IDLE);
    bus.branch_taken_i = 1'b1;
    step("br_int_take", E_TAKE);
    step("br_int_drain0", E_DRAIN);
    step("br_int_drain1", E_DRAIN);
    step("br_int_redirect", E_REDIR);
    check_eq("br_int_epc", bus.epc_o, 16'h0123);
    check_eq("br_int_cause", bus.cause_o, 4'h9);

    // Reset in the middle of DRAIN
    clear_inputs(); bus.id_valid_i = 1'b1; bus.int_req_i = 1'b0;
    step("pre_rst0", E_IDLE);
    step("pre_rst1", E_IDLE);
    bus.eret_i = 1'b1;
    step("eret3", E_ERET);
    bus.eret_i = 1'b0; bus.id_pc_i = 16'h0777; bus.int_req_i = 1'b1;
    step("rst_int_sync0", E_IDLE);
    step("rst_int_sync1", E_IDLE);
    step("rst_int_take", E_TAKE);
    check_eq("rst_int_state", dbg_state, DRAIN);
    RST_N = 1'b0;
    #1;
    check_eq("mid_rst_outputs", observed(), E_IDLE);
    check_eq("mid_rst_state", dbg_state, RUN);
    check_eq("mid_rst_epc", bus.epc_o, 16'h0000);
    check_eq("mid_rst_cause", bus.cause_o, 4'h0);
    bus.int_req_i = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    check_eq("post_rst_int_en", bus.int_en_o, 1'b1);
    step("post_rst_idle", E_IDLE);
    check_eq("post_rst_state", dbg_state, RUN);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
